// File: rtl/axi4lite_master_pkg.sv
// Shared types for the MEM-stage to AXI4-Lite master bridge: response codes,
// channel FSM state encodings and the response classification helper.
package axi4lite_master_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2,
    W_DONE = 2'd3
  } w_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2,
    R_DONE = 2'd3
  } r_state_t;

  // Anything other than OKAY is reported to the core, EXOKAY included.
  function automatic logic resp_is_error(input logic [1:0] resp);
    logic err_s;
    case (resp)
      AXI_RESP_OKAY:   err_s = 1'b0;
      AXI_RESP_EXOKAY: err_s = 1'b1;
      AXI_RESP_SLVERR: err_s = 1'b1;
      AXI_RESP_DECERR: err_s = 1'b1;
      default:         err_s = 1'b1;
    endcase
    return err_s;
  endfunction

endpackage

// File: rtl/axi4lite_master_if.sv
// AXI4-Lite bus bundle between the core-side master and the SoC interconnect.
interface axi4lite_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi4lite_master.sv
// Bridges the MEM-stage level-held start/busy requests onto an AXI4-Lite master
// port using independent write (AW/W/B) and read (AR/R) channel FSMs.
module axi4lite_master
  import axi4lite_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    write_start,
  input  logic [ADDR_WIDTH-1:0]   write_addr,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strobe,
  output logic                    write_busy,
  input  logic                    read_start,
  input  logic [ADDR_WIDTH-1:0]   read_addr,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    read_busy,
  output logic                    write_error,
  output logic                    read_error,
  axi4lite_master_if.master       m_axi
);

  w_state_t                w_state_r;
  r_state_t                r_state_r;
  logic                    aw_done_r;
  logic                    w_done_r;
  logic [ADDR_WIDTH-1:0]   awaddr_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic [DATA_WIDTH/8-1:0] wstrb_r;
  logic                    awvalid_r;
  logic                    wvalid_r;
  logic                    bready_r;
  logic                    write_error_r;
  logic [ADDR_WIDTH-1:0]   araddr_r;
  logic                    arvalid_r;
  logic                    rready_r;
  logic [DATA_WIDTH-1:0]   read_data_r;
  logic                    read_error_r;
  logic                    write_busy_s;
  logic                    read_busy_s;
  logic                    aw_hs_s;
  logic                    w_hs_s;

  assign aw_hs_s = awvalid_r & m_axi.awready;
  assign w_hs_s  = wvalid_r & m_axi.wready;

  // Write channel FSM: AW and W complete independently, then wait for B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_r     <= W_IDLE;
      aw_done_r     <= 1'b0;
      w_done_r      <= 1'b0;
      awaddr_r      <= '0;
      wdata_r       <= '0;
      wstrb_r       <= '0;
      awvalid_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      bready_r      <= 1'b0;
      write_error_r <= 1'b0;
    end else begin
      write_error_r <= 1'b0;
      case (w_state_r)
        W_IDLE: begin
          if (write_start) begin
            awaddr_r  <= write_addr;
            wdata_r   <= write_data;
            wstrb_r   <= write_strobe;
            awvalid_r <= 1'b1;
            wvalid_r  <= 1'b1;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            w_state_r <= W_ADDR;
          end
        end
        W_ADDR: begin
          if (aw_hs_s) begin
            awvalid_r <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid_r <= 1'b0;
            w_done_r <= 1'b1;
          end
          // Either flag may be set this very cycle by a same-cycle handshake.
          if ((aw_done_r | aw_hs_s) & (w_done_r | w_hs_s)) begin
            bready_r  <= 1'b1;
            w_state_r <= W_RESP;
          end
        end
        W_RESP: begin
          if (m_axi.bvalid) begin
            bready_r      <= 1'b0;
            write_error_r <= resp_is_error(m_axi.bresp);
            w_state_r     <= W_DONE;
          end
        end
        W_DONE: begin
          w_state_r <= W_IDLE;
        end
        default: begin
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
          w_state_r <= W_IDLE;
        end
      endcase
    end
  end

  // Read channel FSM: AR handshake, then capture the R beat into read_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_r    <= R_IDLE;
      araddr_r     <= '0;
      arvalid_r    <= 1'b0;
      rready_r     <= 1'b0;
      read_data_r  <= '0;
      read_error_r <= 1'b0;
    end else begin
      read_error_r <= 1'b0;
      case (r_state_r)
        R_IDLE: begin
          if (read_start) begin
            araddr_r  <= read_addr;
            arvalid_r <= 1'b1;
            r_state_r <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (m_axi.arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            r_state_r <= R_DATA;
          end
        end
        R_DATA: begin
          if (m_axi.rvalid) begin
            rready_r     <= 1'b0;
            read_data_r  <= m_axi.rdata;
            read_error_r <= resp_is_error(m_axi.rresp);
            r_state_r    <= R_DONE;
          end
        end
        R_DONE: begin
          r_state_r <= R_IDLE;
        end
        default: begin
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          r_state_r <= R_IDLE;
        end
      endcase
    end
  end

  // Stall decode: busy rises with the request itself and drops in DONE.
  always_comb begin
    write_busy_s = 1'b0;
    read_busy_s  = 1'b0;
    case (w_state_r)
      W_IDLE:  write_busy_s = write_start;
      W_ADDR:  write_busy_s = 1'b1;
      W_RESP:  write_busy_s = 1'b1;
      W_DONE:  write_busy_s = 1'b0;
      default: write_busy_s = 1'b0;
    endcase
    case (r_state_r)
      R_IDLE:  read_busy_s = read_start;
      R_ADDR:  read_busy_s = 1'b1;
      R_DATA:  read_busy_s = 1'b1;
      R_DONE:  read_busy_s = 1'b0;
      default: read_busy_s = 1'b0;
    endcase
  end

  assign write_busy  = write_busy_s;
  assign read_busy   = read_busy_s;
  assign read_data   = read_data_r;
  assign write_error = write_error_r;
  assign read_error  = read_error_r;

  assign m_axi.awaddr  = awaddr_r;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_r;
  assign m_axi.wdata   = wdata_r;
  assign m_axi.wstrb   = wstrb_r;
  assign m_axi.wvalid  = wvalid_r;
  assign m_axi.bready  = bready_r;
  assign m_axi.araddr  = araddr_r;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_r;
  assign m_axi.rready  = rready_r;

endmodule

// File: tb/tb_axi4lite_master.sv
// Directed bench for axi4lite_master: a wait-state-programmable slave, a
// transaction-level model checked every cycle, and literal per-test expectations.
module tb_axi4lite_master;

  logic        clk;
  logic        rst_n;
  logic        write_start;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic        write_busy;
  logic        read_start;
  logic [31:0] read_addr;
  logic [31:0] read_data;
  logic        read_busy;
  logic        write_error;
  logic        read_error;

  axi4lite_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi4lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_start  (write_start),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_strobe (write_strobe),
    .write_busy   (write_busy),
    .read_start   (read_start),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .read_busy    (read_busy),
    .write_error  (write_error),
    .read_error   (read_error),
    .m_axi        (bus.master)
  );

  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Slave configuration: ready/valid asserted after N cycles of waiting.
  int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;

  initial begin
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rresp = 2'b00; bus.rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (bus.awvalid) begin bus.awready = (aw_cnt >= aw_wait); aw_cnt++; end
      else begin bus.awready = 1'b0; aw_cnt = 0; end
      if (bus.wvalid) begin bus.wready = (w_cnt >= w_wait); w_cnt++; end
      else begin bus.wready = 1'b0; w_cnt = 0; end
      if (bus.bready) begin bus.bvalid = (b_cnt >= b_wait); b_cnt++; end
      else begin bus.bvalid = 1'b0; b_cnt = 0; end
      if (bus.arvalid) begin bus.arready = (ar_cnt >= ar_wait); ar_cnt++; end
      else begin bus.arready = 1'b0; ar_cnt = 0; end
      if (bus.rready) begin bus.rvalid = (r_cnt >= r_wait); r_cnt++; end
      else begin bus.rvalid = 1'b0; r_cnt = 0; end
      bus.bresp = bresp_cfg;
      bus.rresp = rresp_cfg;
      bus.rdata = rdata_cfg;
    end
  end

  // Transaction-level model: phase per direction plus outstanding handshakes.
  typedef enum {P_IDLE, P_PEND, P_DONE} phase_t;
  phase_t      wp, rp;
  bit          need_aw, need_w, need_b, need_ar, need_r, werr_flag, rerr_flag;
  logic [31:0] exp_awaddr, exp_wdata, exp_araddr, exp_read_data;
  logic [3:0]  exp_wstrb;
  int          aw_hs_cnt, w_hs_cnt, ar_hs_cnt, werr_cnt, rerr_cnt;
  logic [31:0] ar_addr_q[$];

  initial begin
    wp = P_IDLE; rp = P_IDLE;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk1("rst_awvalid", bus.awvalid, 1'b0);
        chk1("rst_wvalid", bus.wvalid, 1'b0);
        chk1("rst_bready", bus.bready, 1'b0);
        chk1("rst_arvalid", bus.arvalid, 1'b0);
        chk1("rst_rready", bus.rready, 1'b0);
        chk1("rst_write_error", write_error, 1'b0);
        chk1("rst_read_error", read_error, 1'b0);
        chk32("rst_read_data", read_data, 32'h0);
        wp = P_IDLE; rp = P_IDLE;
        need_aw = 0; need_w = 0; need_b = 0; need_ar = 0; need_r = 0;
        werr_flag = 0; rerr_flag = 0; exp_read_data = 32'h0;
      end else begin
        chk1("write_busy", write_busy, (wp == P_PEND) || (wp == P_IDLE && write_start));
        chk1("awvalid", bus.awvalid, need_aw);
        chk1("wvalid", bus.wvalid, need_w);
        chk1("bready", bus.bready, need_b && !need_aw && !need_w);
        if (bus.awvalid) chk32("awaddr", bus.awaddr, exp_awaddr);
        if (bus.wvalid) begin
          chk32("wdata", bus.wdata, exp_wdata);
          chk32("wstrb", 32'(bus.wstrb), 32'(exp_wstrb));
        end
        chk32("awprot", 32'(bus.awprot), 32'h0);
        chk1("write_error", write_error, wp == P_DONE && werr_flag);
        chk1("read_busy", read_busy, (rp == P_PEND) || (rp == P_IDLE && read_start));
        chk1("arvalid", bus.arvalid, need_ar);
        chk1("rready", bus.rready, need_r && !need_ar);
        if (bus.arvalid) chk32("araddr", bus.araddr, exp_araddr);
        chk32("arprot", 32'(bus.arprot), 32'h0);
        chk1("read_error", read_error, rp == P_DONE && rerr_flag);
        chk32("read_data", read_data, exp_read_data);
        if (write_error) werr_cnt++;
        if (read_error) rerr_cnt++;

        // Advance the model to the next cycle from what the upcoming edge will see.
        if (bus.awvalid && bus.awready) begin aw_hs_cnt++; need_aw = 0; end
        if (bus.wvalid && bus.wready) begin w_hs_cnt++; need_w = 0; end
        if (wp == P_DONE) begin
          wp = P_IDLE; werr_flag = 0;
        end else if (wp == P_PEND && bus.bready && bus.bvalid) begin
          need_b = 0; werr_flag = (bus.bresp != 2'b00); wp = P_DONE;
        end else if (wp == P_IDLE && write_start) begin
          exp_awaddr = write_addr; exp_wdata = write_data; exp_wstrb = write_strobe;
          need_aw = 1; need_w = 1; need_b = 1; wp = P_PEND;
        end
        if (bus.arvalid && bus.arready) begin
          ar_hs_cnt++; ar_addr_q.push_back(bus.araddr); need_ar = 0;
        end
        if (rp == P_DONE) begin
          rp = P_IDLE; rerr_flag = 0;
        end else if (rp == P_PEND && bus.rready && bus.rvalid) begin
          need_r = 0; exp_read_data = bus.rdata; rerr_flag = (bus.rresp != 2'b00); rp = P_DONE;
        end else if (rp == P_IDLE && read_start) begin
          exp_araddr = read_addr; need_ar = 1; need_r = 1; rp = P_PEND;
        end
      end
    end
  end

  logic        snap_awvalid;
  logic [31:0] snap_awaddr, snap_wdata, rd_at_done;
  logic [3:0]  snap_wstrb;

  task automatic clear_counts();
    aw_hs_cnt = 0; w_hs_cnt = 0; ar_hs_cnt = 0; werr_cnt = 0; rerr_cnt = 0;
    ar_addr_q.delete();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int stall);
    bit done;
    @(posedge clk); #1;
    write_start = 1'b1; write_addr = a; write_data = d; write_strobe = s;
    stall = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (i == 1) begin
        snap_awvalid = bus.awvalid; snap_awaddr = bus.awaddr;
        snap_wdata = bus.wdata; snap_wstrb = bus.wstrb;
      end
      if (!write_busy) done = 1;
      else stall++;
    end
    chk1("write_completes", done, 1'b1);
    @(posedge clk); #1;
    write_start = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input bit keep, output int stall);
    bit done;
    @(posedge clk); #1;
    read_start = 1'b1; read_addr = a;
    stall = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!read_busy) begin done = 1; rd_at_done = read_data; end
      else stall++;
    end
    chk1("read_completes", done, 1'b1);
    if (!keep) begin
      @(posedge clk); #1;
      read_start = 1'b0;
    end
  endtask

  initial begin
    int st, st2;
    rst_n = 1'b0; write_start = 1'b0; write_addr = 32'h0; write_data = 32'h0;
    write_strobe = 4'h0; read_start = 1'b0; read_addr = 32'h0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk1("reset_write_busy", write_busy, 1'b0);
    chk1("reset_read_busy", read_busy, 1'b0);
    chk32("reset_read_data", read_data, 32'h0);

    // Store, zero-wait slave.
    clear_counts();
    do_write(32'h1000_0004, 32'hCAFE_BABE, 4'b1111, st);
    chk32("sw_stall", 32'(st), 32'd3);
    chk1("sw_awvalid_c1", snap_awvalid, 1'b1);
    chk32("sw_awaddr_c1", snap_awaddr, 32'h1000_0004);
    chk32("sw_wdata_c1", snap_wdata, 32'hCAFE_BABE);
    chk32("sw_wstrb_c1", 32'(snap_wstrb), 32'hF);
    chk32("sw_aw_count", 32'(aw_hs_cnt), 32'd1);
    chk32("sw_w_count", 32'(w_hs_cnt), 32'd1);
    chk32("sw_err_count", 32'(werr_cnt), 32'd0);

    // Load with 2 AR waits and 3 R waits.
    clear_counts();
    ar_wait = 2; r_wait = 3; rdata_cfg = 32'h8765_4321;
    do_read(32'h1000_0008, 1'b0, st);
    chk32("lw_stall", 32'(st), 32'd8);
    chk32("lw_read_data", rd_at_done, 32'h8765_4321);
    chk32("lw_ar_count", 32'(ar_hs_cnt), 32'd1);
    ar_wait = 0; r_wait = 0;

    // wready leads awready by 4 cycles.
    clear_counts();
    aw_wait = 4; w_wait = 0;
    do_write(32'h2000_0000, 32'h0102_0304, 4'b0101, st);
    chk32("wfirst_stall", 32'(st), 32'd7);
    chk32("wfirst_aw_count", 32'(aw_hs_cnt), 32'd1);
    chk32("wfirst_w_count", 32'(w_hs_cnt), 32'd1);

    // AW and W complete in the same cycle.
    clear_counts();
    aw_wait = 2; w_wait = 2;
    do_write(32'h2000_0010, 32'hA5A5_5A5A, 4'b1000, st);
    chk32("same_stall", 32'(st), 32'd5);
    chk32("same_aw_count", 32'(aw_hs_cnt), 32'd1);
    aw_wait = 0; w_wait = 0;

    // Back-to-back loads with read_start held.
    clear_counts();
    rdata_cfg = 32'h1111_2222;
    do_read(32'h0000_0020, 1'b1, st);
    do_read(32'h0000_0024, 1'b0, st2);
    chk32("b2b_stall1", 32'(st), 32'd3);
    chk32("b2b_stall2", 32'(st2), 32'd3);
    chk32("b2b_ar_count", 32'(ar_hs_cnt), 32'd2);
    if (ar_addr_q.size() == 2) begin
      chk32("b2b_addr0", ar_addr_q[0], 32'h0000_0020);
      chk32("b2b_addr1", ar_addr_q[1], 32'h0000_0024);
    end else begin
      chk32("b2b_addr_q_size", 32'(ar_addr_q.size()), 32'd2);
    end

    // Error responses.
    clear_counts();
    bresp_cfg = 2'b10;
    do_write(32'h3000_0000, 32'h5555_AAAA, 4'b1111, st);
    chk32("slverr_stall", 32'(st), 32'd3);
    chk32("slverr_pulses", 32'(werr_cnt), 32'd1);
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b11; rdata_cfg = 32'hDEAD_0001;
    do_read(32'h3000_0004, 1'b0, st);
    chk32("decerr_pulses", 32'(rerr_cnt), 32'd1);
    chk32("decerr_read_data", rd_at_done, 32'hDEAD_0001);
    rresp_cfg = 2'b00;

    // Asynchronous reset while AW is pending.
    aw_wait = 20;
    @(posedge clk); #1;
    write_start = 1'b1; write_addr = 32'h4000_0000; write_data = 32'hFFFF_0000; write_strobe = 4'hF;
    @(posedge clk); #3;
    chk1("pre_rst_awvalid", bus.awvalid, 1'b1);
    rst_n = 1'b0; write_start = 1'b0;
    #1;
    chk1("async_awvalid", bus.awvalid, 1'b0);
    chk1("async_wvalid", bus.wvalid, 1'b0);
    chk1("async_bready", bus.bready, 1'b0);
    chk1("async_write_busy", write_busy, 1'b0);
    chk32("async_read_data", read_data, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    aw_wait = 0;
    clear_counts();
    do_write(32'h1000_0010, 32'h1234_5678, 4'b0011, st);
    chk32("post_rst_stall", 32'(st), 32'd3);
    chk32("post_rst_awaddr", snap_awaddr, 32'h1000_0010);
    chk32("post_rst_wstrb", 32'(snap_wstrb), 32'h3);
    chk32("post_rst_aw_count", 32'(aw_hs_cnt), 32'd1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi4lite_master.md
Name: axi4lite_master

Overview:
- Bridges the core's MEM-stage memory request interface (start/busy, level-held) to an AXI4-Lite master port on the SoC interconnect.
- Runs independent write (AW/W/B) and read (AR/R) channel FSMs.
- Drives the combinational busy that stalls the pipeline, and returns raw 32-bit read data.
- Byte-lane selection and sign/zero extension stay in the MEM stage.

Parameters:
ADDR_WIDTH, 32, AXI address width (only 32 supported)
DATA_WIDTH, 32, AXI data width (only 32 supported)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
write_start  input  1  level request from MEM stage; held high until busy observed low
write_addr  input  32  byte address of store
write_data  input  32  store data, lane-aligned by MEM stage? no: unshifted op2 data
write_strobe  input  4  byte enables
write_busy  output  1  stall while a write is pending
read_start  input  1  level request from MEM stage
read_addr  input  32  byte address of load
read_data  output  32  raw word returned on R channel
read_busy  output  1  stall while a read is pending
write_error  output  1  one-cycle pulse, BRESP != OKAY
read_error  output  1  one-cycle pulse, RRESP != OKAY
m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  32/3/1/1  AW channel, awprot tied 3'b000
m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  W channel
m_axi_bresp/bvalid/bready  in/in/out  2/1/1  B channel
m_axi_araddr/arprot/arvalid/arready  out/out/out/in  32/3/1/1  AR channel, arprot tied 3'b000
m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  R channel

Behaviour:
- Reset (async on rst_n low):
  - Both FSMs go to IDLE.
  - All valid/ready outputs, error pulses and read_data go to 0.
  - Latched address/data go to 0.
- Write FSM states:
  - W_IDLE: on write_start, latch addr/data/strobe and go to W_ADDR.
  - W_ADDR: awvalid and wvalid are both asserted. The AW and W handshakes complete independently and may occur in either order or in the same cycle. Track them with aw_done/w_done flags. A valid deasserts only after its own handshake. Go to W_RESP once both handshakes are done.
  - W_RESP: bready=1. On bvalid, go to W_DONE; write_error pulses if bresp != 2'b00.
  - W_DONE: busy low for exactly one cycle, then go to W_IDLE.
- Read FSM states:
  - R_IDLE: on read_start, latch addr and go to R_ADDR.
  - R_ADDR: arvalid=1 until arready, then go to R_DATA.
  - R_DATA: rready=1. On rvalid, register rdata into read_data and go to R_DONE; read_error pulses if rresp != OKAY.
  - R_DONE: one cycle, then go to R_IDLE.
  - read_data holds its value until the next R handshake.
- busy (combinational):
  - write_busy = (W_IDLE & write_start) | W_ADDR | W_RESP. Same form for read_busy.
  - The pipeline therefore stalls in the same cycle a request first appears.
  - The DONE state guarantees one busy-low cycle, so a level-held start from the next back-to-back instruction is treated as a new request.
- Contract: the MEM stage advances whenever busy is low, so start is never held through DONE by a completed instruction.
- Latency with a zero-wait slave (ready=1, response one cycle after handshake):
  - request cycle 0 → valids high cycle 1 → response cycle 2 → DONE cycle 3 (busy low).
  - Total stall is 3 cycles.
- AXI rules: valids never depend combinationally on ready. Addr/data/strobe stay stable while valid is high. Start inputs are ignored outside IDLE.
- Concurrency: read and write FSMs are independent and may overlap. No ordering is enforced between them; the MEM stage issues only one at a time.
- Reset mid-transaction: outputs drop immediately (the interconnect is reset together with the core).

Decomposition:
- defines.vh gets:
  - AXI response codes: AXI_RESP_OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11.
  - 2-bit state encodings for write and read: IDLE=0, ADDR=1, RESP/DATA=2, DONE=3.
- No sub-module. The two FSMs are symmetric but small, so both live in one file.

Test Plan:
- SW: addr 0x1000_0004, data 0xCAFEBABE, strobe 4'b1111, slave always ready → awaddr/wdata/wstrb correct in cycle 1; write_busy high cycles 0–2, low cycle 3; one AW and one W handshake only.
- LW: addr 0x1000_0008, slave rdata 0x8765_4321 with 2 wait states on arready and 3 on rvalid → read_data=0x87654321 in R_DONE; read_busy low for exactly that cycle; araddr stable throughout wait states.
- Write where wready precedes awready by 4 cycles, and separately where both arrive in the same cycle → W_RESP entered only after both handshakes; wvalid drops after its own handshake.
- Back-to-back loads with read_start held high across both → two AR handshakes with distinct addresses 0x20 then 0x24; one busy-low cycle between them.
- SLVERR: bresp=2'b10, then rresp=2'b11 → write_error/read_error pulse one cycle each; FSMs return to IDLE normally.
- rst_n asserted low while in W_ADDR with awvalid high → all valids/readies 0 asynchronously; after release, FSMs are in IDLE and a fresh store completes correctly.
